sdm_sample_sequencer: RTL and testbench
=======================================

# sdm_sample_sequencer

Sample-rate sequencer in front of the first-order sigma-delta modulator. It buffers incoming signed PCM samples in a small FIFO and presents each sample on the modulator input for exactly `osr` clocks. It controls modulator reset through start, prime, run and drain phases, and flags underruns. It sits between the sample source (valid/ready stream) and the modulator's `x`/`rst` inputs.

## Interface
- `bits`, 12: sample width, signed two's complement; must equal the modulator `bits`.
- `osr`, 64: oversampling ratio in clocks per sample; legal values are 2 or more.
- `depth`, 4: FIFO depth; must be a power of 2 and at least 2.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: run request (level).
- `s_valid`  in  1: source has a sample.
- `s_data`  in  `bits` signed: sample value.
- `s_ready`  out  1: FIFO can accept; equals `!full`, combinational from the registered level.
- `sdm_x`  out  `bits` signed: drives the modulator `x`; registered.
- `sdm_rst`  out  1: drives the modulator `rst`; registered.
- `sample_tick`  out  1: one-cycle pulse in the first cycle a new value is on `sdm_x`.
- `running`  out  1: high in RUN and DRAIN.
- `underrun`  out  1: sticky underrun flag.
- `level`  out  clog2(`depth`)+1: FIFO occupancy, 0..`depth`.

## Operation
- **FIFO**
  - A push occurs when `s_valid && s_ready`. A push is accepted in every state.
  - Pops are issued only by the FSM.
  - Simultaneous push and pop with `level` < `depth`: `level` is unchanged and order is preserved.
  - When full, `s_ready`=0 even if a pop occurs in the same cycle; there is no pass-through.
  - Pointers wrap modulo `depth`.
  - FIFO contents are cleared only by `rst`.
- **FSM states:** IDLE, PRIME, RUN, DRAIN.
- **IDLE**
  - Outputs: `sdm_rst`=1, `sdm_x`=0, `running`=0.
  - `en`=1 moves to PRIME and clears `underrun` on that transition.
- **PRIME**
  - Outputs: `sdm_rst`=1, `sdm_x`=0.
  - `en`=0 returns to IDLE.
  - `level`==`depth` moves to RUN and pops the head in the same edge. On that edge `sdm_x`<=head, `sdm_rst`<=0, `sample_tick`<=1, and the period counter is set to 0.
  - `en`=0 has priority over the full condition.
- **RUN**
  - The period counter (width clog2(`osr`)) increments every cycle.
  - At count `osr`-1 a period boundary occurs and the counter returns to 0.
  - Boundary with FIFO not empty: pop, `sdm_x`<=head, `sample_tick`<=1.
  - Boundary with FIFO empty: `sdm_x`<=0, `underrun`<=1, `sample_tick`<=1. There is no pop and state stays RUN.
  - A push arriving in the boundary cycle with the FIFO empty is not bypassed. It is used at the next boundary.
  - `en`=0 at any cycle moves to DRAIN. The current sample is held until the period completes.
- **DRAIN**
  - The counter continues. No pops occur.
  - At the period boundary: IDLE, `sdm_x`<=0, `sdm_rst`<=1, `running`<=0, no `sample_tick`.
  - `en` is ignored in DRAIN. A restart always passes through IDLE and PRIME.
- **Datapath:** no arithmetic on sample data. Samples pass bit-exact from `s_data` to `sdm_x`.

## Timing
- **Reset values** after `rst` is sampled high:
  - state IDLE, `level`=0, `s_ready`=1, `sdm_x`=0, `sdm_rst`=1, `sample_tick`=0, `running`=0, `underrun`=0.
  - Period counter 0, FIFO pointers 0.
- **Reset mid-operation:** the above values apply at the next edge regardless of state. FIFO data is discarded.
- **Start latency:** if `en` is high and `level` reaches `depth` at edge N, the first sample appears on `sdm_x` with `sdm_rst`=0 after edge N+1.
- **Sample hold:** each sample is held exactly `osr` cycles. `sample_tick` pulses exist only on cycles 0, `osr`, 2·`osr`, ... after the RUN entry.
- **Stop latency:** `en` falling during period cycle c gives IDLE outputs `osr`-c cycles later, measured as for the start latency.
- **Push latency:** a push at edge N raises `level` after edge N. `s_ready` falls in the same cycle that `level`=`depth`.

## Test plan
- **Reset values:** `rst` high for 2 cycles with `s_valid`=1 → after release all outputs hold reset values; no push is accepted during reset.
- **Prime and run** (`osr`=4, `depth`=4): push 100, -200, 2047, -2048, `en`=1 → `sdm_x` equals each value for 4 cycles in order, with `sample_tick` on cycles 0, 4, 8, 12 and `sdm_rst`=0 from cycle 0.
- **Underrun:** after the 4 samples with no further pushes → cycle 16 gives `sdm_x`=0, `underrun`=1, `sample_tick`=1. A push of 5 during cycle 17 appears at cycle 20; `underrun` stays 1.
- **Stop mid-period:** drop `en` at period cycle 1 → held value persists 3 more cycles, then `sdm_rst`=1, `sdm_x`=0, `running`=0. Remaining FIFO samples are kept, and re-`en` re-primes.
- **Backpressure:** `s_valid` held high in IDLE → exactly `depth` samples accepted, then `s_ready`=0. In RUN, after each pop, one new sample is accepted on the following cycle.
- **Reset during RUN** at period cycle 2 with `level`=3 → next cycle in IDLE, `level`=0, `sdm_rst`=1, `sdm_x`=0.

Source files
------------

// File: rtl/sdm_sample_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdm_sample_sequencer_if                                            |
// | Valid/ready PCM sample stream feeding the sample sequencer.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface sdm_sample_sequencer_if #(
    parameter int BITS = 12
);
    logic                   s_valid;
    logic signed [BITS-1:0] s_data;
    logic                   s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/sdm_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdm_sample_sequencer                                               |
// | FIFO-buffered PCM sequencer holding each sample on the SDM for OSR |
// | clocks, with prime/run/drain control of the modulator reset.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sdm_sample_sequencer #(
    parameter int BITS  = 12,
    parameter int OSR   = 64,
    parameter int DEPTH = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    en,
    sdm_sample_sequencer_if.slave  stream,
    output logic signed [BITS-1:0] sdm_x,
    output logic                   sdm_rst,
    output logic                   sample_tick,
    output logic                   running,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(OSR);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(OSR - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PRIME = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic signed [BITS-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_LW-1:0]        r_level;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_next;
    logic signed [BITS-1:0] r_x;
    logic signed [BITS-1:0] w_x_next;
    logic                   r_sdm_rst;
    logic                   w_sdm_rst_next;
    logic                   r_tick;
    logic                   w_tick_next;
    logic                   r_underrun;
    logic                   w_underrun_next;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_boundary;

    assign w_full     = (r_level == c_FULL);
    assign w_empty    = (r_level == '0);
    assign w_push     = stream.s_valid && !w_full;
    assign w_boundary = (r_cnt == c_LAST);

    assign stream.s_ready = !w_full;
    assign sdm_x          = r_x;
    assign sdm_rst        = r_sdm_rst;
    assign sample_tick    = r_tick;
    assign running        = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign underrun       = r_underrun;
    assign level          = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dropping en on the last period cycle finishes the period straight into IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (en) w_state_next = c_PRIME;
            c_PRIME: begin
                if (!en)         w_state_next = c_IDLE;
                else if (w_full) w_state_next = c_RUN;
            end
            c_RUN: begin
                if (!en) w_state_next = w_boundary ? c_IDLE : c_DRAIN;
            end
            default: if (w_boundary) w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_pop           = 1'b0;
        w_x_next        = r_x;
        w_sdm_rst_next  = r_sdm_rst;
        w_tick_next     = 1'b0;
        w_underrun_next = r_underrun;
        w_cnt_next      = '0;
        case (r_state)
            c_IDLE: begin
                w_x_next       = '0;
                w_sdm_rst_next = 1'b1;
                if (en) w_underrun_next = 1'b0;
            end
            c_PRIME: begin
                w_x_next       = '0;
                w_sdm_rst_next = 1'b1;
                if (en && w_full) begin
                    w_pop          = 1'b1;
                    w_x_next       = r_mem[r_rd_ptr];
                    w_sdm_rst_next = 1'b0;
                    w_tick_next    = 1'b1;
                end
            end
            c_RUN: begin
                w_cnt_next = w_boundary ? '0 : r_cnt + c_CW'(1);
                if (w_boundary) begin
                    if (!en) begin
                        w_x_next       = '0;
                        w_sdm_rst_next = 1'b1;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_x_next    = r_mem[r_rd_ptr];
                        w_tick_next = 1'b1;
                    end else begin
                        w_x_next        = '0;
                        w_underrun_next = 1'b1;
                        w_tick_next     = 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_next = w_boundary ? '0 : r_cnt + c_CW'(1);
                if (w_boundary) begin
                    w_x_next       = '0;
                    w_sdm_rst_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= stream.s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cnt      <= '0;
            r_x        <= '0;
            r_sdm_rst  <= 1'b1;
            r_tick     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
            r_cnt      <= w_cnt_next;
            r_x        <= w_x_next;
            r_sdm_rst  <= w_sdm_rst_next;
            r_tick     <= w_tick_next;
            r_underrun <= w_underrun_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdm_sample_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_sdm_sample_sequencer                                            |
// | Directed bench for the sample sequencer with OSR=4, DEPTH=4.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sdm_sample_sequencer;
    localparam int c_BITS  = 12;
    localparam int c_OSR   = 4;
    localparam int c_DEPTH = 4;

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic signed [c_BITS-1:0] sdm_x;
    logic                     sdm_rst;
    logic                     sample_tick;
    logic                     running;
    logic                     underrun;
    logic [2:0]               level;
    int                       n_checks;
    int                       n_errors;

    sdm_sample_sequencer_if #(.BITS(c_BITS)) stream_if ();

    sdm_sample_sequencer #(
        .BITS  (c_BITS),
        .OSR   (c_OSR),
        .DEPTH (c_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .stream      (stream_if.slave),
        .sdm_x       (sdm_x),
        .sdm_rst     (sdm_rst),
        .sample_tick (sample_tick),
        .running     (running),
        .underrun    (underrun),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_run_x(input int c);
        case (c / 4)
            0:       return 100;
            1:       return -200;
            2:       return 2047;
            3:       return -2048;
            4:       return 0;
            5:       return 5;
            default: return 11;
        endcase
    endfunction

    initial begin
        logic signed [c_BITS-1:0] pcm [4];
        int                       lvl_tab [8];
        pcm     = '{12'sd100, -12'sd200, 12'sd2047, -12'sd2048};
        lvl_tab = '{3, 4, 4, 4, 3, 4, 4, 4};
        n_checks = 0;
        n_errors = 0;

        rst = 1'b1;
        en  = 1'b0;
        stream_if.s_valid = 1'b1;
        stream_if.s_data  = 12'sd7;
        step();
        step();
        check("rst_level", 32'(level), 0);
        check("rst_ready", 32'(stream_if.s_ready), 1);
        check("rst_x", 32'(sdm_x), 0);
        check("rst_sdm_rst", 32'(sdm_rst), 1);
        check("rst_tick", 32'(sample_tick), 0);
        check("rst_running", 32'(running), 0);
        check("rst_underrun", 32'(underrun), 0);
        rst = 1'b0;
        stream_if.s_valid = 1'b0;
        step();
        check("post_rst_level", 32'(level), 0);

        // Fill the FIFO in IDLE; a fifth offered sample must be refused.
        for (int i = 0; i < 4; i++) begin
            stream_if.s_valid = 1'b1;
            stream_if.s_data  = pcm[i];
            step();
            check("fill_level", 32'(level), i + 1);
        end
        check("full_ready", 32'(stream_if.s_ready), 0);
        stream_if.s_data = 12'sd999;
        step();
        check("full_hold_level", 32'(level), 4);
        check("idle_sdm_rst", 32'(sdm_rst), 1);
        stream_if.s_valid = 1'b0;

        en = 1'b1;
        step();
        check("prime_sdm_rst", 32'(sdm_rst), 1);
        check("prime_running", 32'(running), 0);
        step();

        for (int c = 0; c < 28; c++) begin
            check("run_x", 32'(sdm_x), exp_run_x(c));
            check("run_tick", 32'(sample_tick), (c % 4 == 0) ? 1 : 0);
            check("run_sdm_rst", 32'(sdm_rst), 0);
            check("run_running", 32'(running), 1);
            check("run_underrun", 32'(underrun), (c >= 16) ? 1 : 0);
            stream_if.s_valid = (c == 17) || (c >= 20 && c <= 22);
            stream_if.s_data  = (c == 17) ? 12'sd5 : (c == 20) ? 12'sd11 :
                                (c == 21) ? 12'sd22 : 12'sd33;
            if (c == 25) en = 1'b0;
            step();
        end
        stream_if.s_valid = 1'b0;
        check("stop_sdm_rst", 32'(sdm_rst), 1);
        check("stop_x", 32'(sdm_x), 0);
        check("stop_running", 32'(running), 0);
        check("stop_tick", 32'(sample_tick), 0);
        check("stop_level_kept", 32'(level), 2);
        check("stop_underrun_sticky", 32'(underrun), 1);

        // Re-prime with the source streaming continuously.
        en = 1'b1;
        stream_if.s_valid = 1'b1;
        stream_if.s_data  = 12'sd44;
        step();
        check("reprime_level", 32'(level), 3);
        check("reprime_underrun_clr", 32'(underrun), 0);
        check("reprime_sdm_rst", 32'(sdm_rst), 1);
        stream_if.s_data = 12'sd55;
        step();
        check("reprime_full", 32'(level), 4);
        check("reprime_ready", 32'(stream_if.s_ready), 0);
        check("reprime_running", 32'(running), 0);
        stream_if.s_data = 12'sd66;
        step();
        for (int c = 0; c < 8; c++) begin
            check("bp_x", 32'(sdm_x), (c < 4) ? 22 : 33);
            check("bp_tick", 32'(sample_tick), (c % 4 == 0) ? 1 : 0);
            check("bp_level", 32'(level), lvl_tab[c]);
            check("bp_ready", 32'(stream_if.s_ready), (lvl_tab[c] == 4) ? 0 : 1);
            step();
        end
        check("bp_x_next", 32'(sdm_x), 44);
        check("bp_level_next", 32'(level), 3);
        stream_if.s_valid = 1'b0;
        step();
        step();
        check("mid_level", 32'(level), 3);
        check("mid_running", 32'(running), 1);
        rst = 1'b1;
        step();
        check("midrst_level", 32'(level), 0);
        check("midrst_sdm_rst", 32'(sdm_rst), 1);
        check("midrst_x", 32'(sdm_x), 0);
        check("midrst_running", 32'(running), 0);
        check("midrst_ready", 32'(stream_if.s_ready), 1);
        rst = 1'b0;
        en  = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
